// File: rtl/seven_seg_scanner.sv
// Time-multiplexed two-bank 7-segment scanner with prescaler, leading-zero blanking and blinking.
// Optional decimal-point outputs are enabled by defining SEVEN_SEG_DP_EN.
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 1,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    SevenSeg_clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] L_digits,
  input  logic [4*NUM_DIGITS-1:0] R_digits,
  input  logic                    L_lzb,
  input  logic                    R_lzb,
  input  logic [NUM_DIGITS-1:0]   L_blink,
  input  logic [NUM_DIGITS-1:0]   R_blink,
`ifdef SEVEN_SEG_DP_EN
  input  logic [NUM_DIGITS-1:0]   L_dp,
  input  logic [NUM_DIGITS-1:0]   R_dp,
  output logic                    L_dp_out,
  output logic                    R_dp_out,
`endif
  output logic [6:0]              L_SevenSegOut,
  output logic [6:0]              R_SevenSegOut,
  output logic [NUM_DIGITS-1:0]   enable,
  output logic                    frame_tick
);

  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned PscW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [NUM_DIGITS-1:0] OneHot0 = NUM_DIGITS'(1);

  logic [PscW-1:0]       r_presc;
  logic [IdxW-1:0]       r_idx;
  logic [FrameW-1:0]     r_frame_cnt;
  logic                  r_blink_phase;
  logic [NUM_DIGITS-1:0] r_enable;
  logic [6:0]            r_l_seg;
  logic [6:0]            r_r_seg;
  logic                  r_frame_tick;

  logic                  w_slot_tick;
  logic                  w_last_idx;
  logic                  w_wrap;
  logic [IdxW-1:0]       w_next_idx;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Decode, then leading-zero blanking, then blink blanking.
  function automatic logic [6:0] bank_seg(input logic [4*NUM_DIGITS-1:0] digits,
                                          input logic                    lzb,
                                          input logic [NUM_DIGITS-1:0]   blink,
                                          input logic                    phase,
                                          input logic [IdxW-1:0]         idx);
    logic [6:0] seg;
    logic       upper_nz;
    seg      = decode(digits[4*idx +: 4]);
    upper_nz = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (i >= int'(idx) && digits[4*i +: 4] != 4'd0) upper_nz = 1'b1;
    end
    if (lzb && idx != '0 && !upper_nz) seg = 7'h00;
    if (phase && blink[idx]) seg = 7'h00;
    return seg;
  endfunction

  always_comb begin
    w_slot_tick = (r_presc == PscW'(SCAN_DIV - 1));
    w_last_idx  = (r_idx == IdxW'(NUM_DIGITS - 1));
    w_wrap      = w_slot_tick && w_last_idx;
    w_next_idx  = w_last_idx ? '0 : r_idx + IdxW'(1);
  end

`ifdef SEVEN_SEG_DP_EN
  logic r_l_dp;
  logic r_r_dp;

  // Decimal point ignores leading-zero blanking but still blinks.
  always_ff @(posedge SevenSeg_clk) begin
    if (!reset) begin
      r_l_dp <= 1'b0;
      r_r_dp <= 1'b0;
    end else if (w_slot_tick) begin
      r_l_dp <= L_dp[w_next_idx] & ~(r_blink_phase & L_blink[w_next_idx]);
      r_r_dp <= R_dp[w_next_idx] & ~(r_blink_phase & R_blink[w_next_idx]);
    end
  end

  assign L_dp_out = r_l_dp;
  assign R_dp_out = r_r_dp;
`endif

  always_ff @(posedge SevenSeg_clk) begin
    if (!reset) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_enable      <= '0;
      r_l_seg       <= 7'h00;
      r_r_seg       <= 7'h00;
      r_frame_tick  <= 1'b0;
    end else begin
      r_presc      <= w_slot_tick ? '0 : r_presc + PscW'(1);
      r_frame_tick <= w_wrap;
      if (w_slot_tick) begin
        r_idx    <= w_next_idx;
        r_enable <= OneHot0 << w_next_idx;
        r_l_seg  <= bank_seg(L_digits, L_lzb, L_blink, r_blink_phase, w_next_idx);
        r_r_seg  <= bank_seg(R_digits, R_lzb, R_blink, r_blink_phase, w_next_idx);
      end
      if (w_wrap) begin
        if (r_frame_cnt == FrameW'(BLINK_FRAMES - 1)) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + FrameW'(1);
        end
      end
    end
  end

  assign L_SevenSegOut = r_l_seg;
  assign R_SevenSegOut = r_r_seg;
  assign enable        = r_enable;
  assign frame_tick    = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench: dut_a runs SCAN_DIV=1/BLINK_FRAMES=2, dut_b runs SCAN_DIV=4.
module tb_seven_seg_scanner;

  logic        clk;
  logic        reset;
  logic [15:0] L_digits, R_digits;
  logic        L_lzb, R_lzb;
  logic [3:0]  L_blink, R_blink;
  logic [6:0]  a_l_seg, a_r_seg, b_l_seg, b_r_seg;
  logic [3:0]  a_en, b_en;
  logic        a_ft, b_ft;
`ifdef SEVEN_SEG_DP_EN
  logic [3:0]  L_dp, R_dp;
  logic        a_l_dp, a_r_dp, b_l_dp, b_r_dp;
`endif

  int pass_cnt = 0;
  int total    = 0;

  seven_seg_scanner #(.NUM_DIGITS(4), .SCAN_DIV(1), .BLINK_FRAMES(2)) dut_a (
    .SevenSeg_clk (clk),
    .reset        (reset),
    .L_digits     (L_digits),
    .R_digits     (R_digits),
    .L_lzb        (L_lzb),
    .R_lzb        (R_lzb),
    .L_blink      (L_blink),
    .R_blink      (R_blink),
`ifdef SEVEN_SEG_DP_EN
    .L_dp         (L_dp),
    .R_dp         (R_dp),
    .L_dp_out     (a_l_dp),
    .R_dp_out     (a_r_dp),
`endif
    .L_SevenSegOut(a_l_seg),
    .R_SevenSegOut(a_r_seg),
    .enable       (a_en),
    .frame_tick   (a_ft)
  );

  seven_seg_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(64)) dut_b (
    .SevenSeg_clk (clk),
    .reset        (reset),
    .L_digits     (L_digits),
    .R_digits     (R_digits),
    .L_lzb        (L_lzb),
    .R_lzb        (R_lzb),
    .L_blink      (L_blink),
    .R_blink      (R_blink),
`ifdef SEVEN_SEG_DP_EN
    .L_dp         (L_dp),
    .R_dp         (R_dp),
    .L_dp_out     (b_l_dp),
    .R_dp_out     (b_r_dp),
`endif
    .L_SevenSegOut(b_l_seg),
    .R_SevenSegOut(b_r_seg),
    .enable       (b_en),
    .frame_tick   (b_ft)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset over one edge, then releases it; index is 0 afterwards.
  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_en [5];
    logic       exp_ft [5];
    exp_en = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_ft = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (a_en !== 4'b0 || a_l_seg !== 7'h00 || a_r_seg !== 7'h00 || a_ft !== 1'b0 ||
          b_en !== 4'b0 || b_l_seg !== 7'h00 || b_r_seg !== 7'h00 || b_ft !== 1'b0)
        $display("FAIL reset_state cyc%0d: a en=%b l=%h r=%h ft=%b b en=%b l=%h r=%h ft=%b, want 0",
                 k, a_en, a_l_seg, a_r_seg, a_ft, b_en, b_l_seg, b_r_seg, b_ft);
      else pass_cnt++;
    end
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (a_en !== exp_en[k] || a_ft !== exp_ft[k])
        $display("FAIL reset_release step%0d: en=%b ft=%b, want en=%b ft=%b",
                 k, a_en, a_ft, exp_en[k], exp_ft[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_prescaler();
    logic [3:0] exp_en  [5];
    logic [6:0] exp_seg [5];
    exp_en  = '{4'b0000, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_seg = '{7'h00, 7'h4F, 7'h5B, 7'h06, 7'h66};
    L_digits = 16'h1234;
    L_lzb    = 1'b0;
    L_blink  = 4'b0;
    do_reset();
    for (int k = 1; k < 20; k++) begin
      tick();
      total++;
      if (b_en !== exp_en[k/4] || b_l_seg !== exp_seg[k/4])
        $display("FAIL prescaler cyc%0d: en=%b seg=%h, want en=%b seg=%h",
                 k, b_en, b_l_seg, exp_en[k/4], exp_seg[k/4]);
      else pass_cnt++;
    end
  endtask

  // Each frame after reset shows digits 1,2,3,0 in that order.
  task automatic test_lzb();
    logic [15:0] vec [3];
    logic [6:0]  exp [3][4];
    vec = '{16'h0050, 16'h0000, 16'h0305};
    exp = '{'{7'h6D, 7'h00, 7'h00, 7'h3F},
            '{7'h00, 7'h00, 7'h00, 7'h3F},
            '{7'h3F, 7'h4F, 7'h00, 7'h6D}};
    R_lzb   = 1'b1;
    R_blink = 4'b0;
    R_digits = vec[0];
    do_reset();
    for (int v = 0; v < 3; v++) begin
      R_digits = vec[v];
      for (int k = 0; k < 4; k++) begin
        tick();
        total++;
        if (a_r_seg !== exp[v][k])
          $display("FAIL lzb vec%0d slot%0d: seg=%h, want %h", v, k, a_r_seg, exp[v][k]);
        else pass_cnt++;
      end
    end
    R_lzb = 1'b0;
  endtask

  task automatic test_blink();
    logic [6:0] exp_d0 [8];
    exp_d0 = '{7'h6F, 7'h6F, 7'h00, 7'h00, 7'h6F, 7'h6F, 7'h00, 7'h00};
    L_digits = 16'h0009;
    L_lzb    = 1'b0;
    L_blink  = 4'b0001;
    do_reset();
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        total++;
        if (a_ft !== (k == 3))
          $display("FAIL blink_frame_tick f%0d k%0d: ft=%b, want %b", f, k, a_ft, (k == 3));
        else pass_cnt++;
        total++;
        if (k == 3 && a_l_seg !== exp_d0[f])
          $display("FAIL blink_digit0 frame%0d: seg=%h, want %h", f, a_l_seg, exp_d0[f]);
        else if (k != 3 && a_l_seg !== 7'h3F)
          $display("FAIL blink_other frame%0d k%0d: seg=%h, want 3f", f, k, a_l_seg);
        else pass_cnt++;
      end
    end
    L_blink = 4'b0;
  endtask

  task automatic test_badcode_midreset();
    L_digits = 16'h0AB0;
    L_lzb    = 1'b0;
    do_reset();
    tick();
    total++;
    if (a_en !== 4'b0010 || a_l_seg !== 7'h00)
      $display("FAIL bad_code_B: en=%b seg=%h, want en=0010 seg=00", a_en, a_l_seg);
    else pass_cnt++;
    tick();
    total++;
    if (a_en !== 4'b0100 || a_l_seg !== 7'h00)
      $display("FAIL bad_code_A: en=%b seg=%h, want en=0100 seg=00", a_en, a_l_seg);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    total++;
    if (a_en !== 4'b0 || a_l_seg !== 7'h00 || a_r_seg !== 7'h00 || a_ft !== 1'b0)
      $display("FAIL mid_reset: en=%b l=%h r=%h ft=%b, want all 0", a_en, a_l_seg, a_r_seg, a_ft);
    else pass_cnt++;
    reset = 1'b1;
    L_digits = 16'h0070;
    tick();
    total++;
    if (a_en !== 4'b0010 || a_l_seg !== 7'h07)
      $display("FAIL mid_reset_resume: en=%b seg=%h, want en=0010 seg=07", a_en, a_l_seg);
    else pass_cnt++;
  endtask

`ifdef SEVEN_SEG_DP_EN
  task automatic test_dp();
    logic exp;
    L_digits = 16'h1111;
    L_dp     = 4'b0010;
    L_blink  = 4'b0010;
    do_reset();
    // blink_phase turns 1 after the second frame, hiding digit 1 and its dp.
    for (int k = 0; k < 16; k++) begin
      tick();
      exp = (k % 4 == 0) && (k < 8);
      total++;
      if (a_l_dp !== exp)
        $display("FAIL dp cyc%0d: dp_out=%b, want %b", k, a_l_dp, exp);
      else pass_cnt++;
    end
    L_dp    = 4'b0;
    L_blink = 4'b0;
  endtask
`endif

  initial begin
    reset    = 1'b0;
    L_digits = 16'h0;
    R_digits = 16'h0;
    L_lzb    = 1'b0;
    R_lzb    = 1'b0;
    L_blink  = 4'b0;
    R_blink  = 4'b0;
`ifdef SEVEN_SEG_DP_EN
    L_dp     = 4'b0;
    R_dp     = 4'b0;
`endif
    test_reset();
    test_prescaler();
    test_lzb();
    test_blink();
    test_badcode_midreset();
`ifdef SEVEN_SEG_DP_EN
    test_dp();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Parametrised time-multiplexed driver for two banks (left/right) of common-enable 7-segment digits.
- Replaces the fixed 4-digit scan logic.
- Adds:
  - a programmable scan prescaler
  - a generic digit count
  - per-bank leading-zero blanking
  - per-digit blinking
- Sits between game/score logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, digits per bank and width of the one-hot enable (2..8).
- SCAN_DIV, 1, clock cycles per digit slot (1 = advance every cycle).
- BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).

Ports:
- SevenSeg_clk  in  1  scan clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- L_digits  in  4*NUM_DIGITS  left-bank BCD codes; digit i at [4i+3:4i], digit 0 least significant.
- R_digits  in  4*NUM_DIGITS  right-bank BCD codes, same packing.
- L_lzb  in  1  left-bank leading-zero blanking enable.
- R_lzb  in  1  right-bank leading-zero blanking enable.
- L_blink  in  NUM_DIGITS  left-bank per-digit blink mask.
- R_blink  in  NUM_DIGITS  right-bank per-digit blink mask.
- L_SevenSegOut  out  7  left segments, bit0=a .. bit6=g, active-high.
- R_SevenSegOut  out  7  right segments, same encoding.
- enable  out  NUM_DIGITS  one-hot digit enable, bit i = digit i, active-high.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Behaviour:
- All state changes on the rising edge of SevenSeg_clk. Reset is sampled only on that edge.
- Reset values:
  - prescaler 0, digit index 0, frame counter 0, blink_phase 0.
  - enable all 0, both segment outputs 7'b0, frame_tick 0.
- Prescaler:
  - counts 0..SCAN_DIV-1 and wraps.
  - slot_tick is asserted in the cycle where prescaler == SCAN_DIV-1.
  - with SCAN_DIV=1, slot_tick is asserted every cycle.
- Digit index:
  - on slot_tick, index <= index+1, wrapping from NUM_DIGITS-1 to 0.
- Output update (all registered):
  - on slot_tick, enable <= one-hot(next index).
  - on slot_tick, each bank's segment output <= decode of the next index's digit after masking.
  - outputs are otherwise held.
  - after reset release, the first slot_tick drives digit 1. The first frame is therefore 1..N-1,0.
  - latency from an input change to the display is at most NUM_DIGITS*SCAN_DIV cycles plus 1.
- Decode:
  - codes 0-9 use the standard patterns (0 = 7'h3F, 1 = 7'h06, 8 = 7'h7F).
  - codes 10-15 decode to blank (7'h00).
- Leading-zero blanking, when the bank's lzb input is 1:
  - digit i (i>0) is blank iff digits i..NUM_DIGITS-1 of that bank are all 0.
  - digit 0 is never blanked by this rule.
  - all-zero input shows a single "0".
- Blink:
  - frame_tick is asserted, for one cycle, on the slot_tick that wraps the index to 0.
  - the frame counter increments on frame_tick.
  - when the frame counter reaches BLINK_FRAMES-1, it resets to 0 and blink_phase toggles.
  - while blink_phase=1, digits whose blink-mask bit is set are blanked. The mask is evaluated at slot_tick.
- Masking is applied in this order: decode, then lzb, then blink. Any rule that blanks a digit forces 7'h00.
- Banks are independent, but share the index, enable and blink_phase.
- Mid-operation reset: all state returns to reset values on the next edge, and scanning restarts from index 0.
- Inputs may change at any time. Only the values present at slot_tick are displayed.

Optional Feature:
- Macro: SEVEN_SEG_DP_EN.
- When defined:
  - adds inputs L_dp and R_dp (NUM_DIGITS each).
  - adds outputs L_dp_out and R_dp_out (1 bit each, registered with the segments).
  - dp_out = dp[next index] on slot_tick.
  - the decimal point ignores lzb blanking but obeys blink blanking.
  - reset value of dp_out is 0.
- When undefined: these ports do not exist and the behaviour is otherwise identical.

Test Plan:
1. Reset held low for 3 cycles -> enable=0, both segment outputs =0, frame_tick=0. Release with SCAN_DIV=1 -> enable sequence 0010, 0100, 1000, 0001, 0010.
2. SCAN_DIV=4, L_digits=16'h1234 -> each enable value is held for 4 cycles. With enable=0001, L_SevenSegOut=7'h66 ("4"). With enable=1000, L_SevenSegOut=7'h06 ("1").
3. R_digits=16'h0050, R_lzb=1:
   - digits 3 and 2 are blank (7'h00).
   - digit 1 shows 7'h6D.
   - digit 0 shows 7'h3F.
   - R_digits=16'h0000 -> only digit 0 shows 7'h3F.
4. BLINK_FRAMES=2, SCAN_DIV=1, L_blink=4'b0001, L_digits=16'h0009:
   - digit 0 shows 7'h6F for 2 frames, then 7'h00 for 2 frames, repeating.
   - frame_tick pulses once every 4 cycles.
5. Input code 4'hB on any digit -> 7'h00. Reset asserted mid-frame at index 2 -> next edge gives enable=0, and scanning resumes from index 0.
6. With SEVEN_SEG_DP_EN defined, L_dp=4'b0010 -> L_dp_out=1 only while enable=0010. With blink masking the digit in blink_phase=1, L_dp_out=0.
